// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN = 2'b01, HOLD = 2'b10} state_t;
  localparam logic [0:3][0:3][3:0] KEYMAP = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };
  localparam logic [0:3][3:0] COL_DRIVE = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: multi-stage synchronizer for asynchronous pad inputs.
module sync_2ff #(
  parameter int W = 1,
  parameter int STAGES = 2,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] ff;
  always_ff @(posedge clk)
    if (!reset) ff <= {STAGES{INIT}};
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix and holds the column of a pressed key until release.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 37500,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_pressed
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  logic          tick;
  logic [3:0]    rows_s;
  logic [1:0]    col, col_n, row_idx;
  logic [3:0]    code_n;
  logic          pressed_n;
  state_t        state, state_n;

  sync_2ff #(.W(4), .STAGES(SYNC_STAGES), .INIT(4'hF)) u_sync (
    .clk(clk), .reset(reset), .d(rows), .q(rows_s)
  );

  assign tick = cnt == CW'(SCAN_DIV - 1);
  assign row_idx = !rows_s[0] ? 2'd0 : !rows_s[1] ? 2'd1 : !rows_s[2] ? 2'd2 : 2'd3;

  always_ff @(posedge clk)
    if (!reset) begin
      state       <= SCAN;
      cnt         <= '0;
      col         <= '0;
      key_code    <= 4'h0;
      key_pressed <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= tick ? '0 : cnt + 1'b1;
      col         <= col_n;
      key_code    <= code_n;
      key_pressed <= pressed_n;
    end

  always_comb begin
    state_n   = state;
    col_n     = col;
    code_n    = key_code;
    pressed_n = key_pressed;
    case (state)
      SCAN: if (tick) begin
        if (rows_s != 4'hF) begin
          code_n    = KEYMAP[row_idx][col];
          pressed_n = 1'b1;
          state_n   = HOLD;
        end else col_n = col + 2'd1;
      end
      HOLD: if (tick && rows_s == 4'hF) begin
        pressed_n = 1'b0;
        col_n     = col + 2'd1;
        state_n   = SCAN;
      end
      default: begin
        state_n   = SCAN;
        col_n     = '0;
        pressed_n = 1'b0;
      end
    endcase
  end

  always_comb cols = COL_DRIVE[col];
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed table, corner sequences and randomized model check for keypad_scanner.
module tb_keypad_scanner;
  localparam int DIV = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] rows = 4'hF, cols, key_code;
  logic key_pressed;
  int tests = 0, fails = 0;

  keypad_scanner #(.SCAN_DIV(DIV), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key_code(key_code), .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  int km[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  logic [3:0] hist[2];
  int m_cnt, m_col, m_held, m_code;

  // Keypad behaviour from its rules: rows seen two edges late, decisions every DIV-th edge.
  task automatic model_step();
    logic [3:0] rs;
    int r;
    if (!reset) begin
      hist = '{4'hF, 4'hF};
      m_cnt = 0; m_col = 0; m_held = 0; m_code = 0;
    end else begin
      rs = hist[0];
      hist = '{hist[1], rows};
      if (m_cnt % DIV == DIV - 1) begin
        if (m_held == 0) begin
          if (rs != 4'hF) begin
            r = 3;
            for (int i = 3; i >= 0; i--) if (!rs[i]) r = i;
            m_code = km[r * 4 + m_col];
            m_held = 1;
          end else m_col = (m_col + 1) % 4;
        end else if (rs == 4'hF) begin
          m_held = 0;
          m_col = (m_col + 1) % 4;
        end
      end
      m_cnt++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got cols=%b code=%h pressed=%b, expected cols=%b code=%h pressed=%b",
               name, got[8:5], got[4:1], got[0], exp[8:5], exp[4:1], exp[0]);
    end
  endtask

  typedef struct {
    logic [3:0] rows;
    int         n;
    logic [3:0] cols;
    logic [3:0] code;
    logic       pressed;
  } vec_t;
  vec_t v[14];
  int hold;
  logic [3:0] ecols;

  initial begin
    v[0]  = '{4'hF, 4, 4'b1101, 4'h0, 1'b0};
    v[1]  = '{4'hF, 4, 4'b1011, 4'h0, 1'b0};
    v[2]  = '{4'hF, 4, 4'b0111, 4'h0, 1'b0};
    v[3]  = '{4'hF, 4, 4'b1110, 4'h0, 1'b0};
    v[4]  = '{4'hF, 4, 4'b1101, 4'h0, 1'b0};
    v[5]  = '{4'hF, 4, 4'b1011, 4'h0, 1'b0};
    v[6]  = '{4'hD, 4, 4'b1011, 4'h6, 1'b1};
    v[7]  = '{4'hD, 4, 4'b1011, 4'h6, 1'b1};
    v[8]  = '{4'hF, 4, 4'b0111, 4'h6, 1'b0};
    v[9]  = '{4'h7, 4, 4'b0111, 4'hD, 1'b1};
    v[10] = '{4'hF, 4, 4'b1110, 4'hD, 1'b0};
    v[11] = '{4'h6, 4, 4'b1110, 4'h1, 1'b1};
    v[12] = '{4'h7, 4, 4'b1110, 4'h1, 1'b1};
    v[13] = '{4'hF, 4, 4'b1101, 4'h1, 1'b0};

    repeat (3) cyc();
    check("reset", {cols, key_code, key_pressed}, {4'b1110, 4'h0, 1'b0});
    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rows = v[i].rows;
      repeat (v[i].n) cyc();
      check($sformatf("vec%0d", i), {cols, key_code, key_pressed}, {v[i].cols, v[i].code, v[i].pressed});
    end

    // Capture on column 1 row 0, then reset while the key is still held.
    rows = 4'hE;
    repeat (4) cyc();
    check("hold_before_reset", {cols, key_code, key_pressed}, {4'b1101, 4'h2, 1'b1});
    reset = 1'b0;
    cyc();
    check("reset_mid_hold", {cols, key_code, key_pressed}, {4'b1110, 4'h0, 1'b0});
    reset = 1'b1;
    rows = 4'hF;
    cyc();

    reset = 1'b0;
    cyc();
    reset = 1'b1;
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        rows = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
        hold = $urandom_range(1, 14);
      end
      hold--;
      reset = ($urandom_range(0, 299) != 0);
      cyc();
      ecols = 4'hF & ~(4'h1 << m_col);
      check("random", {cols, key_code, key_pressed}, {ecols, 4'(m_code), m_held[0]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad and produces a 4-bit key code plus a level key_pressed flag. This stage sits directly upstream of the keypad debouncer, which consumes key_code and key_pressed. Columns are driven one-hot active-low. Rows are read active-low (external pull-ups) through a 2-flop synchronizer. The scanner freezes on the column of a detected key until that key is released.

Parameters:
SCAN_DIV, 37500, clk cycles per scan tick (80 Hz at 3 MHz clk); legal range ≥ 2
SYNC_STAGES, 2, synchronizer depth on the row inputs; legal range ≥ 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
rows  input  4  keypad rows, active-low, asynchronous to clk
cols  output  4  keypad column drive, one-hot active-low (bit i low = column i driven)
key_code  output  4  hex value of the captured key
key_pressed  output  1  high while a captured key is held

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=SCAN, tick counter=0, col index=0
  - cols=4'b1110, key_code=4'h0, key_pressed=0
  - synchronizer flops=4'b1111
- Tick: the counter counts 0..SCAN_DIV-1 and wraps. tick=1 for one cycle when counter==SCAN_DIV-1. All state decisions happen only on tick cycles.
- rows_s is the synchronized rows (SYNC_STAGES flops). Decisions always use rows_s, never raw rows.
- Column dwell: a column is driven for one full tick period before it is sampled, which gives the rows time to settle.
- State SCAN, on tick:
  - If rows_s != 4'b1111: capture row index r = lowest-numbered low row (row 0 has priority).
  - key_code <= KEYMAP[r][col]; key_pressed <= 1; state -> HOLD. Column is not advanced.
  - Else: col <= (col+1) mod 4 (3 wraps to 0); cols updates in the same cycle.
- State HOLD, on tick:
  - If rows_s == 4'b1111: key_pressed <= 0; col <= (col+1) mod 4; state -> SCAN.
  - Else: remain in HOLD. key_code is not updated, even if a different row in the same column goes low.
- Keys in other columns are invisible during HOLD, because only the held column is driven.
- key_code retains its last value after release; it changes only on the next capture.
- Latency: a press on the currently driven column is reported 1 tick plus ≤ SYNC_STAGES cycles after it appears. Worst case across columns is 4 ticks.
- Release is reported at the first tick where rows_s reads all-high.
- Reset mid-HOLD forces the reset values on the next posedge clk; no partial output survives.
- KEYMAP, indexed [row][col]:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E,0,F,D
- Illegal state encodings recover to SCAN with col=0.
- Widths: the tick counter is $clog2(SCAN_DIV) bits; col is 2 bits, and wrap-around is natural overflow.

Decomposition:
- keypad_pkg holds:
  - the state enum (SCAN, HOLD)
  - KEYMAP as a 4x4 array of 4-bit constants
  - the column-drive constant for each index
- Sub-module sync_2ff (parameterized width and stages) synchronizes rows. It is reusable by other pad-facing inputs.

Test Plan:
All scenarios use SCAN_DIV=4.
- Reset: hold reset=0 for 3 cycles -> cols=1110, key_code=0, key_pressed=0. The first tick after release advances to cols=1101.
- Idle scan: rows=1111 for 20 ticks -> cols cycles 1110,1101,1011,0111,1110... and key_pressed stays 0.
- Single key: hold row1 low only while column 2 is driven -> at the next tick key_code=6 and key_pressed=1, and cols stays 1011 while held. Release row1 -> key_pressed=0 at the following tick and cols=0111.
- Priority and freeze: rows 0 and 3 both low on column 0 -> key_code=1. While in HOLD, release row0 but keep row3 low -> still HOLD with key_code=1. Then release all -> key_pressed=0.
- Wrap and row3 mapping: press on column 3 with row3 low -> key_code=D. After release, the next column is 1110.
- Reset mid-HOLD: assert reset while key_pressed=1 -> the next edge gives key_pressed=0, cols=1110, key_code=0.
